cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
Per-cache miss-handling controller that sits between a cache's tag/data arrays and the shared pipelined main memory (memory4c). On a miss it waits for the memory grant, then issues the block's word reads back-to-back. It counts returned words, steering each into the data array, and pulses the tag-write on the last word. One instance is used per cache: I-cache and D-cache.

Parameters:
BLOCK_WORDS, 8, 16-bit words per cache block (power of two; block = 2*BLOCK_WORDS bytes)
ADDR_W, 16, byte-address width

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
miss_detected  input  1  cache lookup missed this cycle (level, held until fill done)
miss_address  input  ADDR_W  byte address that missed
grant  input  1  shared memory free for this cache (arbiter output; 0 while other cache is filling)
memory_data_valid  input  1  memory4c returned a word this cycle
fsm_busy  output  1  stall to pipeline; fill pending or in progress
memory_enable  output  1  issue a read to memory this cycle
memory_address  output  ADDR_W  word address being issued
write_data_array  output  1  write current memory word into data array
fill_word_index  output  log2(BLOCK_WORDS)  word slot in block for write_data_array
write_tag_array  output  1  one-cycle pulse: write tag and set valid

Behaviour:
- States: IDLE, WAIT, FILL. Registers: state, base (block-aligned address), issue_cnt, ret_cnt (each log2(BLOCK_WORDS)+1 bits).
- Reset (sync, rst=1 at posedge): state=IDLE, counters=0, base=0. All outputs are 0, including memory_address, from the cycle after reset. Reset mid-FILL abandons the fill. Memory returns still in flight are ignored because IDLE ignores memory_data_valid.
- IDLE:
  - fsm_busy=0.
  - miss_detected & grant -> FILL.
  - miss_detected & ~grant -> WAIT.
  - On either transition, latch base = miss_address with low log2(2*BLOCK_WORDS) bits cleared, and clear both counters.
  - fsm_busy is combinationally 1 in the miss cycle, so the pipeline stalls immediately.
- WAIT:
  - fsm_busy=1.
  - grant -> FILL.
  - If miss_detected drops (flush or redirect) -> IDLE with no memory access.
  - memory_data_valid ignored.
- FILL, issue side:
  - memory_enable=1 while issue_cnt<BLOCK_WORDS.
  - memory_address = base + 2*issue_cnt.
  - issue_cnt increments every cycle while issuing, so reads go back-to-back with no gaps.
  - After BLOCK_WORDS issues, memory_enable=0 and memory_address holds its last value.
- FILL, return side:
  - write_data_array = memory_data_valid.
  - fill_word_index = ret_cnt[low bits].
  - ret_cnt increments on each valid.
  - On the valid with ret_cnt==BLOCK_WORDS-1: write_tag_array=1 that same cycle, and next state is IDLE.
  - fsm_busy stays 1 through that cycle and drops the following cycle.
- FILL ignores miss_detected and grant; once issued, a fill always completes.
- Issue and return overlap in the same cycle. memory_data_valid arriving before any issue is impossible from memory4c and is counted anyway (no check).
- Fill latency with 4-cycle memory: grant cycle T; issues T+1..T+8; returns T+5..T+12; tag pulse T+12; fsm_busy=0 at T+13.
- memory_address wraps modulo 2^ADDR_W; the block is aligned, so it never crosses a block.
- A new miss in the cycle fsm_busy drops is handled normally from IDLE.

Test Plan:
1. Reset then idle, miss_detected=0 for 5 cycles -> all outputs 0; memory_enable never asserted.
2. miss_address=0x1236 with grant=1, 4-cycle memory model ->
   - memory_address 0x1230,0x1232,…,0x123E on 8 consecutive cycles;
   - write_data_array on 8 cycles with fill_word_index 0..7;
   - write_tag_array single pulse coincident with index 7;
   - fsm_busy low exactly 13 cycles after the miss.
3. miss with grant=0 for 6 cycles, then grant=1 ->
   - fsm_busy=1 throughout;
   - no memory_enable before grant;
   - fill starts the cycle after grant, same sequence as scenario 2.
4. In WAIT, drop miss_detected -> IDLE next cycle; no memory_enable and no tag write ever.
5. Assert rst after the 3rd return during FILL -> state IDLE, all outputs 0 next cycle; the remaining 5 memory_data_valid pulses produce no write_data_array or write_tag_array.
6. Memory model with irregular valid gaps (valid on returns 1,3,4,7,…) -> fill_word_index still 0..7 in order; tag pulse on the 8th valid only. Then back-to-back miss at 0xFFF0 -> addresses 0xFFF0..0xFFFE with no wrap error.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: waits for the shared-memory grant, issues one block
// of back-to-back word reads, and steers the returned words into the data array.
module cache_fill_fsm #(
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic                           grant,
    input  logic                           memory_data_valid,
    output logic                           fsm_busy,
    output logic                           memory_enable,
    output logic [ADDR_W-1:0]              memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_index,
    output logic                           write_tag_array
);

    localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned OFF_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   last_addr;
    logic [CNT_W-1:0]    issue_cnt;
    logic [CNT_W-1:0]    ret_cnt;

    logic                issuing;
    logic                ret_valid;
    logic                last_ret;
    logic [ADDR_W-1:0]   issue_addr;

    // Issue and return sides run independently inside FILL.
    always_comb begin
        issuing    = (state == ST_FILL) && (issue_cnt < CNT_FULL);
        ret_valid  = (state == ST_FILL) && memory_data_valid;
        last_ret   = ret_valid && (ret_cnt == CNT_LAST);
        issue_addr = base + ADDR_W'({issue_cnt, 1'b0});
    end

    // Busy rises in the miss cycle itself so the pipeline stalls without a bubble.
    always_comb begin
        fsm_busy         = (state != ST_IDLE) || miss_detected;
        memory_enable    = issuing;
        memory_address   = issuing ? issue_addr : last_addr;
        write_data_array = ret_valid;
        fill_word_index  = ret_cnt[IDX_W-1:0];
        write_tag_array  = last_ret;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            base      <= '0;
            last_addr <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_detected) begin
                        state     <= grant ? ST_FILL : ST_WAIT;
                        base      <= {miss_address[ADDR_W-1:OFF_W], OFF_W'(0)};
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    // A withdrawn miss never touches memory.
                    if (!miss_detected) begin
                        state <= ST_IDLE;
                    end else if (grant) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        last_addr <= issue_addr;
                    end
                    if (ret_valid) begin
                        ret_cnt <= ret_cnt + CNT_W'(1);
                    end
                    if (last_ret) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a 4-cycle pipelined memory model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        grant;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word_index;
    logic        write_tag_array;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    int exp_addr[$];
    int exp_idx[$];
    bit exp_tag[$];
    int due_q[$];

    int          stall_base = -100;
    logic [31:0] stall_mask = '0;

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .grant             (grant),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_enable     (memory_enable),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_index   (fill_word_index),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit stalled(input int c);
        int k;
        k = c - stall_base;
        return (k >= 0 && k < 32) ? stall_mask[k] : 1'b0;
    endfunction

    // Memory: a read issued in cycle j returns in cycle j+4, later if the return is stalled.
    initial begin
        memory_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (memory_enable === 1'b1) due_q.push_back(cyc + 4);
            @(posedge clk);
            #1;
            memory_data_valid = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc && !stalled(cyc)) begin
                memory_data_valid = 1'b1;
                void'(due_q.pop_front());
            end
        end
    end

    // Monitor: pops expected issues/writes whenever the DUT presents one.
    initial begin
        int e;
        bit t;
        forever begin
            @(negedge clk);
            if (memory_enable === 1'b1) begin
                check(exp_addr.size() != 0, "issue_expected", 1, 0);
                if (exp_addr.size() != 0) begin
                    e = exp_addr.pop_front();
                    check(int'(memory_address) == e, "issue_addr", int'(memory_address), e);
                end
            end
            if (write_data_array === 1'b1) begin
                check(exp_idx.size() != 0, "write_expected", 1, 0);
                if (exp_idx.size() != 0) begin
                    e = exp_idx.pop_front();
                    t = exp_tag.pop_front();
                    check(int'(fill_word_index) == e, "fill_index", int'(fill_word_index), e);
                    check(write_tag_array == t, "tag_pulse", int'(write_tag_array), int'(t));
                end
            end else if (write_tag_array !== 1'b0) begin
                check(write_tag_array === 1'b0, "tag_without_write", int'(write_tag_array), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_fill(input int base);
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(base + 2 * i);
            exp_idx.push_back(i);
            exp_tag.push_back(i == 7);
        end
    endtask

    // Called in the grant cycle; returns at the negedge of the tag-pulse cycle.
    task automatic run_fill(input int t_grant);
        int first_iss, last_iss, n_iss;
        bit busy_ok, seen;
        first_iss = -1; last_iss = -1; n_iss = 0; busy_ok = 1'b1; seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (fsm_busy !== 1'b1) busy_ok = 1'b0;
            if (memory_enable === 1'b1) begin
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
                n_iss++;
            end
            if (write_tag_array === 1'b1) seen = 1'b1;
            else tick();
        end
        check(seen, "tag_seen", int'(seen), 1);
        check(busy_ok, "busy_during_fill", int'(busy_ok), 1);
        check(first_iss == t_grant + 1, "first_issue_offset", first_iss - t_grant, 1);
        check(last_iss == t_grant + 8 && n_iss == 8, "issue_burst_end", last_iss - t_grant, 8);
    endtask

    task automatic finish_fill(input int t_grant, input int lat);
        tick();
        miss_detected = 1'b0;
        grant = 1'b0;
        @(negedge clk);
        check(fsm_busy == 1'b0, "busy_drop", int'(fsm_busy), 0);
        check(cyc - t_grant == lat, "fill_latency", cyc - t_grant, lat);
        check(!memory_enable && !write_tag_array, "quiet_after_fill",
              int'({memory_enable, write_tag_array}), 0);
    endtask

    initial begin
        int t, t2;
        rst = 1'b1; miss_detected = 1'b0; miss_address = '0; grant = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Idle after reset: everything low.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check({fsm_busy, memory_enable, memory_address, write_data_array,
                   fill_word_index, write_tag_array} == 23'd0, "idle_outputs",
                  int'({fsm_busy, memory_enable, memory_address, write_data_array,
                        fill_word_index, write_tag_array}), 0);
            tick();
        end

        // Miss with immediate grant.
        miss_detected = 1'b1; miss_address = 16'h1236; grant = 1'b1; t = cyc;
        push_fill(16'h1230);
        run_fill(t);
        finish_fill(t, 13);

        // Miss waits six cycles for grant.
        tick();
        miss_detected = 1'b1; miss_address = 16'h0A0E; grant = 1'b0;
        push_fill(16'h0A00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check(fsm_busy && !memory_enable, "wait_stall",
                  int'({fsm_busy, memory_enable}), 2);
            tick();
        end
        grant = 1'b1; t = cyc;
        run_fill(t);
        finish_fill(t, 13);

        // Miss withdrawn while waiting.
        tick();
        miss_detected = 1'b1; miss_address = 16'h3456; grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick();
        end
        miss_detected = 1'b0;
        @(negedge clk);
        check(fsm_busy == 1'b1, "wait_busy_on_drop", int'(fsm_busy), 1);
        tick();
        grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(!fsm_busy && !memory_enable && !write_tag_array, "abandon_idle",
                  int'({fsm_busy, memory_enable, write_tag_array}), 0);
            tick();
        end

        // Reset in the cycle of the 3rd return.
        miss_detected = 1'b1; miss_address = 16'h2000; grant = 1'b1; t = cyc;
        for (int i = 0; i < 7; i++) exp_addr.push_back(16'h2000 + 2 * i);
        for (int i = 0; i < 3; i++) begin
            exp_idx.push_back(i);
            exp_tag.push_back(1'b0);
        end
        repeat (7) tick();
        rst = 1'b1; miss_detected = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check({fsm_busy, memory_enable, memory_address, write_data_array,
               fill_word_index, write_tag_array} == 23'd0, "reset_mid_fill",
              int'({fsm_busy, memory_enable, memory_address, write_data_array,
                    fill_word_index, write_tag_array}), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            check(!write_data_array && !write_tag_array && !memory_enable, "post_reset_quiet",
                  int'({write_data_array, write_tag_array, memory_enable}), 0);
        end
        check(exp_addr.size() == 0 && exp_idx.size() == 0, "reset_fill_drained",
              exp_addr.size() + exp_idx.size(), 0);

        // Irregular return gaps, then a back-to-back miss at the top of memory.
        tick();
        miss_detected = 1'b1; miss_address = 16'h4A5C; grant = 1'b1; t = cyc;
        stall_base = t;
        stall_mask = 32'h0000_0340;
        push_fill(16'h4A50);
        run_fill(t);
        tick();
        miss_address = 16'hFFF0; t2 = cyc;
        check(t2 - t == 16, "gap_fill_latency", t2 - t, 16);
        push_fill(16'hFFF0);
        run_fill(t2);
        finish_fill(t2, 13);

        repeat (3) tick();
        check(exp_addr.size() == 0, "issue_queue_empty", exp_addr.size(), 0);
        check(exp_idx.size() == 0, "write_queue_empty", exp_idx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
